// File: rtl/seven_seg_scan_decoder.sv
// Recovers a multi-digit BCD number from a scanned, active-low
// seven-segment bus and presents each complete frame on valid/ready.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic                    out_err,
    output logic                    out_ovf
);

    localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   prev_an;
    logic [6:0]              prev_seg;
    logic [7:0]              cnt;
    logic [7:0]              cnt_next;
    logic                    captured;
    logic                    captured_next;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    frame_err;
    logic [4*NUM_DIGITS-1:0] slots;
    logic                    an_ok;
    logic                    same;
    logic                    cap;
    logic [NUM_DIGITS-1:0]   cap_mask;
    logic [3:0]              dec_bcd;
    logic                    dec_err;
    logic                    complete;

    assign an_ok    = $onehot(~an);
    assign same     = an_ok && (an == prev_an) && (seg == prev_seg);
    assign complete = &seen;

    // Dwell length and once-per-dwell capture decision
    always_comb begin
        cnt_next      = 8'd0;
        cap           = 1'b0;
        captured_next = 1'b0;
        cap_mask      = '0;
        if (same) begin
            cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
        if (an_ok) begin
            cap           = (cnt_next >= CAP_AT) && !(same && captured);
            captured_next = cap || (same && captured);
        end
        if (cap) begin
            cap_mask = ~an;
        end
    end

    // Segment pattern to BCD; unknown patterns map to F
    always_comb begin
        dec_bcd = 4'h0;
        dec_err = 1'b0;
        case (seg)
            7'b1000000: dec_bcd = 4'h0;
            7'b1111001: dec_bcd = 4'h1;
            7'b0100100: dec_bcd = 4'h2;
            7'b0110000: dec_bcd = 4'h3;
            7'b0011001: dec_bcd = 4'h4;
            7'b0010010: dec_bcd = 4'h5;
            7'b0000010: dec_bcd = 4'h6;
            7'b1111000: dec_bcd = 4'h7;
            7'b0000000: dec_bcd = 4'h8;
            7'b0011000: dec_bcd = 4'h9;
            default: begin
                dec_bcd = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Stability filter history and per-digit frame assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_an   <= '0;
            prev_seg  <= '0;
            cnt       <= 8'd0;
            captured  <= 1'b0;
            seen      <= '0;
            frame_err <= 1'b0;
            slots     <= '0;
        end else begin
            prev_an  <= an;
            prev_seg <= seg;
            cnt      <= cnt_next;
            captured <= captured_next;
            if (complete) begin
                seen      <= cap_mask;
                frame_err <= cap && dec_err;
            end else begin
                seen      <= seen | cap_mask;
                frame_err <= frame_err | (cap && dec_err);
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    slots[4*i +: 4] <= dec_bcd;
                end
            end
        end
    end

    // Output register: load, hold under backpressure, or drop with overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bcd <= '0;
            out_val <= 1'b0;
            out_err <= 1'b0;
            out_ovf <= 1'b0;
        end else if (complete) begin
            if (!out_val || out_rdy) begin
                out_bcd <= slots;
                out_err <= frame_err;
                out_val <= 1'b1;
            end else begin
                out_ovf <= 1'b1;
            end
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule
